mem_bus_initiator: RTL and testbench

Processor-side bus master for the memory controller's multiplexed 16-bit address/data bus. It accepts one `instr_t` request (read or write, page/location address), drives the address phase, and then transfers a 4-word burst: it sources write data or captures read data. It finishes by returning a single-cycle response carrying the assembled 64-bit buffer. It is the initiator counterpart to the memory controllers mapped at `MEMPAGE1` (4'h2) and `MEMPAGE2` (4'hF).

---
 rtl/mem_bus_initiator.sv | 133 +++++++++++++
 tb/tb_mem_bus_initiator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_initiator.sv
// Initiator for the multiplexed address/data memory bus: one address beat, a burst of data beats, one response.
// Optional page filtering is enabled by defining MC_PAGE_CHECK_EN.
module mem_bus_initiator #(
  parameter int BUSWIDTH        = 16,
  parameter int DATAPAYLOADSIZE = 4,
  parameter int DBUFWIDTH       = 64
) (
  input  logic                 clk,
  input  logic                 resetH,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [16:0]          req_instr,
  input  logic [DBUFWIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DBUFWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 AddrValid,
  output logic                 rw_,
  output logic [BUSWIDTH-1:0]  AddrData_out,
  output logic                 AddrData_oe,
  input  logic [BUSWIDTH-1:0]  AddrData_in
);

  localparam logic [3:0] MEMPAGE1 = 4'h2;
  localparam logic [3:0] MEMPAGE2 = 4'hF;
  localparam int CW =
    (DATAPAYLOADSIZE > 1) ? $clog2(DATAPAYLOADSIZE) : 1;

  typedef struct packed {
    logic        InstrType;
    logic [3:0]  page;
    logic [11:0] loc;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE, ADDR, DATA, RESP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  instr_t               r_instr;
  logic [DBUFWIDTH-1:0] r_wdata;
  logic [DBUFWIDTH-1:0] r_rdata;
  logic [CW-1:0]        r_beat;
  logic                 r_err;
  logic                 w_accept;
  logic                 w_bad_page;
  logic                 w_last;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_last   = (r_beat == CW'(DATAPAYLOADSIZE - 1));

`ifdef MC_PAGE_CHECK_EN
  assign w_bad_page = (req_instr[15:12] != MEMPAGE1) &&
                      (req_instr[15:12] != MEMPAGE2);
`else
  assign w_bad_page = 1'b0;
`endif

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      r_instr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr <= instr_t'(req_instr);
        r_wdata <= req_wdata;
        r_beat  <= '0;
        r_err   <= w_bad_page;
      end
      if (r_state == DATA) begin
        r_beat <= r_beat + 1'b1;
        if (r_instr.InstrType)
          r_rdata[int'(r_beat)*BUSWIDTH +: BUSWIDTH]
            <= AddrData_in;
      end
    end
  end

  // Outputs decode from state only; reset also masks req_ready.
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    AddrValid    = 1'b0;
    rw_          = 1'b1;
    AddrData_out = '0;
    AddrData_oe  = 1'b0;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    rsp_rdata    = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = !resetH;
        if (w_accept)
          w_next = w_bad_page ? RESP : ADDR;
      end
      ADDR: begin
        AddrValid    = 1'b1;
        rw_          = r_instr.InstrType;
        AddrData_out =
          BUSWIDTH'({r_instr.page, r_instr.loc});
        AddrData_oe  = 1'b1;
        w_next       = DATA;
      end
      DATA: begin
        rw_ = r_instr.InstrType;
        if (!r_instr.InstrType) begin
          AddrData_oe  = 1'b1;
          AddrData_out =
            r_wdata[int'(r_beat)*BUSWIDTH +: BUSWIDTH];
        end
        if (w_last) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        if (r_instr.InstrType && !r_err)
          rsp_rdata = r_rdata;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator with a cycle-offset reference model.
// Honours MC_PAGE_CHECK_EN for the page-filter expectations.
module tb_mem_bus_initiator;

  logic        clk = 1'b0;
  logic        resetH;
  logic        req_valid;
  logic        req_ready;
  logic [16:0] req_instr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        AddrValid;
  logic        rw_;
  logic [15:0] AddrData_out;
  logic        AddrData_oe;
  logic [15:0] AddrData_in;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_bus_initiator dut (
    .clk          (clk),
    .resetH       (resetH),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_instr    (req_instr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .AddrValid    (AddrValid),
    .rw_          (rw_),
    .AddrData_out (AddrData_out),
    .AddrData_oe  (AddrData_oe),
    .AddrData_in  (AddrData_in)
  );

  // Model: off = cycles since acceptance (-1 when idle).
  // 1 = address, 2..5 = data beats, 6 = response.
  int          off     = -1;
  logic        m_type  = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [63:0] m_wdata = '0;
  logic [63:0] m_rdata = '0;
  logic        m_err   = 1'b0;

  function automatic logic bad_page(input logic [3:0] p);
`ifdef MC_PAGE_CHECK_EN
    return (p != 4'h2) && (p != 4'hF);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge resetH) begin
    if (resetH) begin
      off <= -1;
    end else if (off == -1) begin
      if (req_valid) begin
        m_type  <= req_instr[16];
        m_addr  <= req_instr[15:0];
        m_wdata <= req_wdata;
        m_err   <= bad_page(req_instr[15:12]);
        off     <= bad_page(req_instr[15:12]) ? 6 : 1;
      end
    end else begin
      if (off >= 2 && off <= 5 && m_type)
        m_rdata[(off-2)*16 +: 16] <= AddrData_in;
      off <= (off == 6) ? -1 : off + 1;
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic        inb;
    logic [15:0] e_out;
    logic [63:0] e_rd;
    inb   = (off >= 2) && (off <= 5);
    e_out = '0;
    if (off == 1)
      e_out = m_addr;
    else if (inb && !m_type)
      e_out = m_wdata[(off-2)*16 +: 16];
    e_rd = (off == 6 && m_type && !m_err) ? m_rdata : '0;
    chk("req_ready", 64'(req_ready),
        64'((off == -1) && !resetH));
    chk("AddrValid", 64'(AddrValid), 64'(off == 1));
    chk("rw_", 64'(rw_),
        64'((off >= 1 && off <= 5) ? m_type : 1'b1));
    chk("AddrData_oe", 64'(AddrData_oe),
        64'(off == 1 || (inb && !m_type)));
    chk("AddrData_out", 64'(AddrData_out), 64'(e_out));
    chk("rsp_valid", 64'(rsp_valid), 64'(off == 6));
    chk("rsp_err", 64'(rsp_err),
        64'(off == 6 && m_err));
    chk("rsp_rdata", rsp_rdata, e_rd);
  endtask

  // Check at the falling edge, then drive the responder.
  task automatic step();
    @(negedge clk);
    check_model();
    if (off >= 2 && off <= 5)
      AddrData_in = 16'(16'h1111 * (off - 1));
    else
      AddrData_in = 16'hDEAD;
  endtask

  task automatic issue(input logic [16:0] ins,
                       input logic [63:0] wd);
    req_valid = 1'b1;
    req_instr = ins;
    req_wdata = wd;
  endtask

  initial begin
    logic [63:0] w1;
    logic [63:0] w2;
    resetH      = 1'b1;
    req_valid   = 1'b0;
    req_instr   = '0;
    req_wdata   = '0;
    AddrData_in = 16'hDEAD;
    step();
    step();
    chk("rst rw_", 64'(rw_), 64'(1'b1));
    chk("rst req_ready", 64'(req_ready), 64'(1'b0));
    resetH = 1'b0;
    step();
    chk("post-rst ready", 64'(req_ready), 64'(1'b1));

    // Write burst
    issue({1'b0, 16'h2010}, 64'hDDDD_CCCC_BBBB_AAAA);
    step();
    req_valid = 1'b0;
    chk("wr addr", 64'(AddrData_out), 64'h2010);
    chk("wr AddrValid", 64'(AddrValid), 64'(1'b1));
    chk("wr rw_", 64'(rw_), 64'(1'b0));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("wr beat", 64'(AddrData_out),
          64'(16'hAAAA + 16'(k) * 16'h1111));
      chk("wr oe", 64'(AddrData_oe), 64'(1'b1));
    end
    step();
    chk("wr rsp_valid", 64'(rsp_valid), 64'(1'b1));
    chk("wr rsp_err", 64'(rsp_err), 64'(1'b0));
    chk("wr rsp_rdata", rsp_rdata, 64'h0);
    step();
    chk("wr ready again", 64'(req_ready), 64'(1'b1));

    // Read burst
    issue({1'b1, 16'hF0FF}, 64'h0123_4567_89AB_CDEF);
    step();
    req_valid = 1'b0;
    chk("rd addr", 64'(AddrData_out), 64'hF0FF);
    chk("rd rw_", 64'(rw_), 64'(1'b1));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rd oe", 64'(AddrData_oe), 64'(1'b0));
    end
    step();
    chk("rd rsp_valid", 64'(rsp_valid), 64'(1'b1));
    chk("rd rsp_rdata", rsp_rdata,
        64'h4444_3333_2222_1111);
    step();

    // Back-to-back with payload changing mid-flight
    w1 = 64'h1234_5678_9ABC_DEF0;
    w2 = 64'hFFFF_EEEE_0000_5555;
    issue({1'b0, 16'hF123}, w1);
    step();
    issue({1'b1, 16'h2ABC}, w2);
    chk("b2b ready N+1", 64'(req_ready), 64'(1'b0));
    step();
    chk("b2b beat0", 64'(AddrData_out), 64'hDEF0);
    for (int k = 3; k <= 6; k++) begin
      step();
      chk("b2b ready busy", 64'(req_ready), 64'(1'b0));
    end
    step();
    chk("b2b ready N+7", 64'(req_ready), 64'(1'b1));
    step();
    req_valid = 1'b0;
    chk("b2b AddrValid N+8", 64'(AddrValid), 64'(1'b1));
    chk("b2b addr N+8", 64'(AddrData_out), 64'h2ABC);
    for (int k = 0; k < 5; k++) step();
    chk("b2b rd rdata", rsp_rdata,
        64'h4444_3333_2222_1111);
    step();

    // Page filter
    issue({1'b1, 16'h5000}, '0);
    step();
    req_valid = 1'b0;
`ifdef MC_PAGE_CHECK_EN
    chk("pg rsp_valid", 64'(rsp_valid), 64'(1'b1));
    chk("pg rsp_err", 64'(rsp_err), 64'(1'b1));
    chk("pg rsp_rdata", rsp_rdata, 64'h0);
    chk("pg AddrValid", 64'(AddrValid), 64'(1'b0));
    step();
    chk("pg ready N+2", 64'(req_ready), 64'(1'b1));
`else
    chk("pg addr", 64'(AddrData_out), 64'h5000);
    chk("pg AddrValid", 64'(AddrValid), 64'(1'b1));
    for (int k = 0; k < 5; k++) step();
    chk("pg rsp_valid", 64'(rsp_valid), 64'(1'b1));
    chk("pg rsp_err", 64'(rsp_err), 64'(1'b0));
    step();
`endif

    // Reset during write beat 2
    issue({1'b0, 16'h2FFF}, 64'h9999_8888_7777_6666);
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("pre-rst oe", 64'(AddrData_oe), 64'(1'b1));
    #2;
    resetH = 1'b1;
    #1;
    chk("async oe", 64'(AddrData_oe), 64'(1'b0));
    chk("async AddrValid", 64'(AddrValid), 64'(1'b0));
    chk("async out", 64'(AddrData_out), 64'h0);
    chk("async ready", 64'(req_ready), 64'(1'b0));
    step();
    step();
    resetH = 1'b0;
    step();
    chk("rel ready", 64'(req_ready), 64'(1'b1));
    for (int k = 0; k < 7; k++) begin
      step();
      chk("no rsp", 64'(rsp_valid), 64'(1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
